hack_rom_loader: RTL and testbench

Instruction-memory front end for the Hack CPU core. It receives a program as a byte stream over a valid/ready link and writes it into an on-chip instruction ROM. Once the program is verified, it serves `instr` combinationally from the CPU's `PC`. It holds the CPU idle (`run`=0, `instr`=0) until a complete, checksum-valid image has been loaded.

---
 rtl/hack_rom_loader_pkg.sv | 25 ++
 rtl/hack_rom_loader_if.sv | 30 +++
 rtl/hack_rom_loader_rom.sv | 29 ++
 rtl/hack_rom_loader.sv | 137 +++++++++++++
 tb/tb_hack_rom_loader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hack_rom_loader_pkg.sv
// Shared Hack package: loader FSM state encoding, core widths and the
// memory-map constants also used by the CPU core.
package hack_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_WORD_W = 16;

  // Data-memory map seen by the CPU core.
  localparam logic [HACK_WORD_W-1:0] HACK_RAM_BASE     = 16'h0000;
  localparam int                     HACK_RAM_WORDS    = 16384;
  localparam logic [HACK_WORD_W-1:0] HACK_SCREEN_BASE  = 16'h4000;
  localparam int                     HACK_SCREEN_WORDS = 8192;
  localparam logic [HACK_WORD_W-1:0] HACK_KBD_ADDR     = 16'h6000;

  typedef enum logic [2:0] {
    CNT_HI  = 3'd0,
    CNT_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHK     = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } load_state_t;

endpackage

// File: rtl/hack_rom_loader_if.sv
// Loader bus: byte-stream input link, reload control, and the CPU-facing
// instruction fetch / status signals.
//   master: byte source + CPU (drives rx_data/rx_valid/reload/pc)
//   slave : the loader (drives rx_ready/instr/run/error/word_count)
interface hack_rom_loader_if #(
  parameter int ADDR_W = 15
);
  import hack_pkg::*;

  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   reload;
  logic [ADDR_W-1:0]      pc;
  logic [HACK_WORD_W-1:0] instr;
  logic                   run;
  logic                   error;
  logic [ADDR_W:0]        word_count;

  modport master (
    output rx_data, rx_valid, reload, pc,
    input  rx_ready, instr, run, error, word_count
  );

  modport slave (
    input  rx_data, rx_valid, reload, pc,
    output rx_ready, instr, run, error, word_count
  );

endinterface

// File: rtl/hack_rom_loader_rom.sv
// hack_rom: DEPTH x 16 instruction store.
//   clk          write clock
//   we/waddr/wdata  synchronous write port
//   raddr/rdata     asynchronous read port (CPU fetch is same-cycle)
module hack_rom
  import hack_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [HACK_WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [HACK_WORD_W-1:0] rdata
);

  logic [HACK_WORD_W-1:0] mem [DEPTH];

  // No reset on the array: contents survive reload, and stale words are
  // hidden by the word_count guard in the loader.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: receives a program image as a byte stream, writes it
// into hack_rom, verifies its XOR checksum and then serves instructions to
// the CPU. The CPU is held idle (run=0, instr=0) until a valid image lands.
// Image: N hi, N lo, N x {word hi, word lo}, checksum (XOR of all prior bytes).
//   clk, rst  system clock, async active-high reset
//   bus       hack_rom_loader_if.slave (byte link, reload, pc/instr, status)
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DEPTH  = 32768
) (
  input logic               clk,
  input logic               rst,
  hack_rom_loader_if.slave  bus
);

  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  load_state_t state, state_nx;

  logic [7:0]             byte_hi;    // count hi in CNT_HI, word hi in DATA_HI
  logic [7:0]             xacc;       // running XOR of accepted bytes
  logic [ADDR_W-1:0]      waddr;
  logic [ADDR_W:0]        word_count;
  logic [15:0]            n16;
  logic                   n_big;
  logic                   last_word;
  logic                   acc;
  logic                   restart;
  logic                   we;
  logic [HACK_WORD_W-1:0] rdata;

  assign n16       = {byte_hi, bus.rx_data};
  assign n_big     = {1'b0, n16} > DEPTH17;
  assign last_word = ((ADDR_W+1)'({1'b0, waddr}) + (ADDR_W+1)'(1)) == word_count;
  assign acc       = bus.rx_valid && bus.rx_ready;
  assign restart   = bus.reload && (state == RUN || state == ERROR);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CNT_HI;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      CNT_HI:  if (acc) state_nx = CNT_LO;
      CNT_LO:  if (acc) begin
                 if (n_big)          state_nx = ERROR;
                 else if (n16 == '0) state_nx = CHK;
                 else                state_nx = DATA_HI;
               end
      DATA_HI: if (acc) state_nx = DATA_LO;
      DATA_LO: if (acc) state_nx = last_word ? CHK : DATA_HI;
      CHK:     if (acc) state_nx = (bus.rx_data == xacc) ? RUN : ERROR;
      RUN,
      ERROR:   if (bus.reload) state_nx = CNT_HI;
      default: state_nx = CNT_HI;
    endcase
  end

  // Outputs
  always_comb begin
    bus.rx_ready = 1'b0;
    bus.run      = 1'b0;
    bus.error    = 1'b0;
    we           = 1'b0;
    bus.instr    = '0;
    unique case (state)
      CNT_HI, CNT_LO, DATA_HI, CHK: bus.rx_ready = 1'b1;
      DATA_LO: begin
        bus.rx_ready = 1'b1;
        we           = bus.rx_valid;
      end
      RUN: begin
        bus.run = 1'b1;
        // Guard hides stale words left by an earlier, longer image.
        if ({1'b0, bus.pc} < word_count) bus.instr = rdata;
      end
      ERROR:   bus.error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: byte assembler, checksum accumulator, write address, count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_hi    <= '0;
      xacc       <= '0;
      waddr      <= '0;
      word_count <= '0;
    end else if (restart) begin
      xacc       <= '0;
      waddr      <= '0;
      word_count <= '0;
    end else if (acc) begin
      unique case (state)
        CNT_HI: begin
          byte_hi <= bus.rx_data;
          xacc    <= xacc ^ bus.rx_data;
        end
        CNT_LO: begin
          xacc       <= xacc ^ bus.rx_data;
          word_count <= n_big ? '0 : (ADDR_W+1)'(n16);
        end
        DATA_HI: begin
          byte_hi <= bus.rx_data;
          xacc    <= xacc ^ bus.rx_data;
        end
        DATA_LO: begin
          xacc  <= xacc ^ bus.rx_data;
          waddr <= waddr + 1'b1;
        end
        CHK: if (bus.rx_data != xacc) word_count <= '0;
        default: ;
      endcase
    end
  end

  assign bus.word_count = word_count;

  hack_rom #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rom (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata ({byte_hi, bus.rx_data}),
    .raddr (bus.pc),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_hack_rom_loader.sv
module tb_hack_rom_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hack_rom_loader_if #(.ADDR_W(15)) bus ();

  hack_rom_loader #(.ADDR_W(15), .DEPTH(32768)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [14:0] pc;
    logic [15:0] instr;
  } vec_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } sb_t;

  int checks   = 0;
  int failures = 0;

  sb_t         sbq[$];
  logic [15:0] img[$];
  vec_t        tv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gaps;
    gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gaps) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      tick();
    end
    chk("rx_ready_while_loading", bus.rx_ready, 1'b1);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Sends img[] as a full image; checksum is XORed with flip (0 = good).
  task automatic load_img(input int gap_max, input logic [7:0] flip);
    logic [7:0]  x;
    logic [15:0] n;
    n = 16'(img.size());
    x = n[15:8] ^ n[7:0];
    send_byte(n[15:8], gap_max);
    send_byte(n[7:0], gap_max);
    for (int i = 0; i < img.size(); i++) begin
      logic [15:0] w;
      w = img[i];
      sbq.push_back('{addr: 15'(i), data: w});
      x = x ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], gap_max);
      send_byte(w[7:0], gap_max);
    end
    send_byte(x ^ flip, gap_max);
  endtask

  task automatic drain_sb();
    while (sbq.size() > 0) begin
      sb_t e;
      e = sbq.pop_front();
      bus.pc = e.addr;
      #1;
      chk($sformatf("rom_word[%0d]", e.addr), bus.instr, e.data);
    end
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rx_ready"}, bus.rx_ready, 1'b1);
    chk({tag, "_run"}, bus.run, 1'b0);
    chk({tag, "_error"}, bus.error, 1'b0);
    chk({tag, "_instr"}, bus.instr, 16'h0000);
    chk({tag, "_word_count"}, bus.word_count, 16'd0);
  endtask

  initial begin
    tv[0] = '{pc: 15'd0,      instr: 16'h0005};
    tv[1] = '{pc: 15'd1,      instr: 16'hEC10};
    tv[2] = '{pc: 15'd2,      instr: 16'h0000};
    tv[3] = '{pc: 15'h7FFF,   instr: 16'h0000};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.reload   = 1'b0;
    bus.pc       = '0;
    tick();
    tick();
    chk_idle("reset_held");
    rst = 1'b0;
    tick();
    chk_idle("reset");

    // Two-word image, good checksum 0xFB
    img = '{16'h0005, 16'hEC10};
    load_img(0, 8'h00);
    chk("t1_run", bus.run, 1'b1);
    chk("t1_word_count", bus.word_count, 16'd2);
    chk("t1_rx_ready", bus.rx_ready, 1'b0);
    sbq.delete();
    for (int i = 0; i < 4; i++) begin
      bus.pc = tv[i].pc;
      #1;
      chk($sformatf("t1_vec%0d_instr", i), bus.instr, tv[i].instr);
    end
    // Bytes offered in RUN must be ignored
    bus.rx_data = 8'h55; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    chk("t1_ignore_run", bus.run, 1'b1);
    chk("t1_ignore_wc", bus.word_count, 16'd2);
    pulse_reload();
    chk("reload_run", bus.run, 1'b0);
    chk("reload_rx_ready", bus.rx_ready, 1'b1);
    chk("reload_wc", bus.word_count, 16'd0);

    // Same image, checksum forced to 0x00
    load_img(0, 8'hFB);
    sbq.delete();
    bus.pc = 15'd0;
    #1;
    chk("badchk_error", bus.error, 1'b1);
    chk("badchk_run", bus.run, 1'b0);
    chk("badchk_instr", bus.instr, 16'h0000);
    chk("badchk_wc", bus.word_count, 16'd0);
    chk("badchk_rx_ready", bus.rx_ready, 1'b0);
    tick();
    chk("badchk_sticky", bus.error, 1'b1);
    pulse_reload();
    chk_idle("reload_err");

    // Oversized header 0x8001
    send_byte(8'h80, 0);
    chk("big_not_yet", bus.error, 1'b0);
    send_byte(8'h01, 0);
    chk("big_error", bus.error, 1'b1);
    chk("big_wc", bus.word_count, 16'd0);
    chk("big_rx_ready", bus.rx_ready, 1'b0);
    bus.rx_data = 8'hAA; bus.rx_valid = 1'b1;
    tick(); tick();
    bus.rx_valid = 1'b0;
    chk("big_still_error", bus.error, 1'b1);
    pulse_reload();
    chk_idle("reload_big");

    // Empty image; reload pulse mid-header must be ignored
    send_byte(8'h00, 0);
    pulse_reload();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("n0_run", bus.run, 1'b1);
    chk("n0_wc", bus.word_count, 16'd0);
    for (int p = 0; p < 6; p++) begin
      bus.pc = (p == 5) ? 15'h7FFF : 15'(p);
      #1;
      chk($sformatf("n0_instr_pc%0d", bus.pc), bus.instr, 16'h0000);
    end
    pulse_reload();

    // 100 random words with random bubbles
    img.delete();
    for (int i = 0; i < 100; i++) img.push_back(16'($urandom));
    load_img(3, 8'h00);
    chk("r100_run", bus.run, 1'b1);
    chk("r100_wc", bus.word_count, 16'd100);
    drain_sb();
    bus.pc = 15'd100;
    #1;
    chk("r100_past_end", bus.instr, 16'h0000);
    pulse_reload();

    // Reset while sitting in DATA_LO
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    #2 rst = 1'b1;
    #1;
    chk_idle("midrst_async");
    rst = 1'b0;
    tick();
    chk_idle("midrst");
    img = '{16'h1234, 16'hBEEF, 16'h0F0F};
    load_img(1, 8'h00);
    chk("midrst_run", bus.run, 1'b1);
    chk("midrst_wc", bus.word_count, 16'd3);
    drain_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
